word_serializer: RTL and testbench

- Transmit side of the reader-FIFO byte stream that the DMA verifier consumes.
- Pops 32-bit words from the reader FIFO and emits them as bytes, MSB first, with a 2-bit byte-lane counter.
- Emits exactly the programmed buffer length in bytes per transfer, then pulses done.
- Sits between the reader FIFO read port and the checker/consumer.

---
 rtl/word_serializer.sv | 161 ++++++++++++++++
 tb/tb_word_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: pops 32-bit words from the reader FIFO and emits them as
// bytes, MSB first, with a 2-bit lane counter. It emits exactly the programmed
// number of bytes per transfer, then pulses o_Done for one cycle.
module word_serializer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              Start,
  input  logic [LEN_W-1:0]  i_RCC_BUFFER_LENGTH,
  input  logic [DATA_W-1:0] i_FIFO_rd_data,
  input  logic              i_FIFO_empty,
  output logic              o_FIFO_rd_en,
  output logic [7:0]        o_serialized_output,
  output logic              o_serialized_output_valid,
  output logic [1:0]        o_Serialize_Counter,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_underflow
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift,
    StStall,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [1:0]         lane_q, lane_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               underflow_q, underflow_d;
  // Set when the next word was popped on the lane-2 cycle; rd_data is valid at lane 3.
  logic               pf_q, pf_d;
  logic [7:0]         lane_byte;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= StIdle;
      word_q      <= '0;
      lane_q      <= '0;
      remaining_q <= '0;
      underflow_q <= 1'b0;
      pf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      remaining_q <= remaining_d;
      underflow_q <= underflow_d;
      pf_q        <= pf_d;
    end
  end

  // Select the byte addressed by the current lane, MSB first.
  always_comb begin
    lane_byte = 8'h00;
    unique case (lane_q)
      2'd0: lane_byte = word_q[31:24];
      2'd1: lane_byte = word_q[23:16];
      2'd2: lane_byte = word_q[15:8];
      2'd3: lane_byte = word_q[7:0];
      default: lane_byte = 8'h00;
    endcase
  end

  // Next-state logic and outputs.
  always_comb begin
    state_d                   = state_q;
    word_d                    = word_q;
    lane_d                    = lane_q;
    remaining_d               = remaining_q;
    underflow_d               = underflow_q;
    pf_d                      = pf_q;
    o_FIFO_rd_en              = 1'b0;
    o_serialized_output       = 8'h00;
    o_serialized_output_valid = 1'b0;
    o_Serialize_Counter       = 2'd0;
    o_Done                    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          remaining_d = i_RCC_BUFFER_LENGTH;
          underflow_d = 1'b0;
          pf_d        = 1'b0;
          lane_d      = 2'd0;
          state_d     = (i_RCC_BUFFER_LENGTH == '0) ? StDone : StFetch;
        end
      end

      // Waiting here for the first word is not an underflow.
      StFetch: begin
        if (!i_FIFO_empty) begin
          o_FIFO_rd_en = 1'b1;
          state_d      = StLoad;
        end
      end

      StLoad: begin
        word_d  = i_FIFO_rd_data;
        lane_d  = 2'd0;
        pf_d    = 1'b0;
        state_d = StShift;
      end

      StShift: begin
        o_serialized_output_valid = 1'b1;
        o_serialized_output       = lane_byte;
        o_Serialize_Counter       = lane_q;
        if (remaining_q != '0) begin
          remaining_d = remaining_q - LEN_W'(1);
        end
        if (remaining_q == LEN_W'(1)) begin
          // Last byte; any unread lanes of the current word are dropped.
          state_d = StDone;
        end else begin
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd2 && remaining_q > LEN_W'(2) && !i_FIFO_empty) begin
            o_FIFO_rd_en = 1'b1;
            pf_d         = 1'b1;
          end
          // Reaching lane 3 with bytes still owed means a next word was needed.
          if (lane_q == 2'd3) begin
            if (pf_q) begin
              word_d = i_FIFO_rd_data;
              lane_d = 2'd0;
              pf_d   = 1'b0;
            end else begin
              underflow_d = 1'b1;
              state_d     = StStall;
            end
          end
        end
      end

      StStall: begin
        if (!i_FIFO_empty) begin
          o_FIFO_rd_en = 1'b1;
          state_d      = StLoad;
        end
      end

      StDone: begin
        o_Done  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign o_Busy      = (state_q != StIdle);
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer with a small behavioural reader FIFO.
module tb_word_serializer;

  localparam int unsigned LEN_W = 6;

  logic             CLK = 1'b0;
  logic             RESETn = 1'b0;
  logic             Start = 1'b0;
  logic [LEN_W-1:0] len_in = '0;
  logic [31:0]      rd_data = '0;
  logic             fifo_empty;
  logic             rd_en;
  logic [7:0]       ser;
  logic             valid;
  logic [1:0]       cnt;
  logic             busy;
  logic             done;
  logic             underflow;

  int n_cmp = 0;
  int n_err = 0;

  word_serializer #(.DATA_W(32), .LEN_W(LEN_W)) dut (
    .CLK                      (CLK),
    .RESETn                   (RESETn),
    .Start                    (Start),
    .i_RCC_BUFFER_LENGTH      (len_in),
    .i_FIFO_rd_data           (rd_data),
    .i_FIFO_empty             (fifo_empty),
    .o_FIFO_rd_en             (rd_en),
    .o_serialized_output      (ser),
    .o_serialized_output_valid(valid),
    .o_Serialize_Counter      (cnt),
    .o_Busy                   (busy),
    .o_Done                   (done),
    .o_underflow              (underflow)
  );

  always #5 CLK = ~CLK;

  // Reader FIFO model: data appears the cycle after a pop.
  logic [31:0] fifo_mem [32];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int bad_rd = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge CLK) begin
    if (rd_en) begin
      if (fifo_empty) begin
        bad_rd <= bad_rd + 1;
      end else begin
        rd_data <= fifo_mem[rd_ptr[4:0]];
        rd_ptr  <= rd_ptr + 1;
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr[4:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-transfer observations.
  logic [63:0] bytes_seen;
  logic [15:0] lanes_seen;
  int          nvalid, first_v, last_v, done_cyc, done_cnt, npop;
  logic        uf_at1;

  // Start a transfer and observe 24 cycles. Cycle c is sampled at the c-th
  // falling edge after the edge that accepted Start.
  task automatic run_xfer(input logic [LEN_W-1:0] len, input int late_cyc,
                          input logic [31:0] late_word, input logic [31:0] busy_mask);
    int pop0;
    bytes_seen = '0;
    lanes_seen = '0;
    nvalid     = 0;
    first_v    = -1;
    last_v     = -1;
    done_cyc   = -1;
    done_cnt   = 0;
    uf_at1     = 1'b0;
    @(negedge CLK);
    pop0   = pop_cnt;
    Start  = 1'b1;
    len_in = len;
    for (int c = 1; c <= 24; c++) begin
      @(negedge CLK);
      if (valid) begin
        bytes_seen = {bytes_seen[55:0], ser};
        lanes_seen = {lanes_seen[13:0], cnt};
        nvalid++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 1) uf_at1 = underflow;
      Start = busy_mask[c];
      if (c == late_cyc) push(late_word);
    end
    Start = 1'b0;
    npop  = pop_cnt - pop0;
  endtask

  initial begin
    logic found;
    int   pop_before;

    // Reset state.
    repeat (2) @(negedge CLK);
    check_val("reset_outputs", 64'({busy, valid, done, rd_en, underflow, cnt, ser}), 64'h0);
    RESETn = 1'b1;
    @(negedge CLK);

    // L=8, both words present.
    push(32'h11223344);
    push(32'h55667788);
    run_xfer(6'd8, 0, 32'h0, 32'h0);
    check_val("l8_bytes", bytes_seen, 64'h1122334455667788);
    check_val("l8_lanes", 64'(lanes_seen), 64'h1B1B);
    check_val("l8_nvalid", 64'(nvalid), 64'd8);
    check_val("l8_first", 64'(first_v), 64'd3);
    check_val("l8_last", 64'(last_v), 64'd10);
    check_val("l8_done_cyc", 64'(done_cyc), 64'd11);
    check_val("l8_done_cnt", 64'(done_cnt), 64'd1);
    check_val("l8_pops", 64'(npop), 64'd2);
    check_val("l8_underflow", 64'(underflow), 64'd0);

    // L=6: partial second word.
    push(32'h11223344);
    push(32'h55667788);
    run_xfer(6'd6, 0, 32'h0, 32'h0);
    check_val("l6_bytes", bytes_seen, 64'h0000112233445566);
    check_val("l6_lanes", 64'(lanes_seen), 64'h01B1);
    check_val("l6_nvalid", 64'(nvalid), 64'd6);
    check_val("l6_last", 64'(last_v), 64'd8);
    check_val("l6_done_cyc", 64'(done_cyc), 64'd9);
    check_val("l6_pops", 64'(npop), 64'd2);

    // L=0: Done right after Start, no read, no data.
    run_xfer(6'd0, 0, 32'h0, 32'h0);
    check_val("l0_done_cyc", 64'(done_cyc), 64'd1);
    check_val("l0_nvalid", 64'(nvalid), 64'd0);
    check_val("l0_pops", 64'(npop), 64'd0);
    check_val("l0_busy_end", 64'(busy), 64'd0);

    // L=8, second word arrives late: stall after lane 3 of the first word.
    push(32'h11223344);
    run_xfer(6'd8, 10, 32'h55667788, 32'h0);
    check_val("uf_bytes", bytes_seen, 64'h1122334455667788);
    check_val("uf_nvalid", 64'(nvalid), 64'd8);
    check_val("uf_first", 64'(first_v), 64'd3);
    check_val("uf_last", 64'(last_v), 64'd15);
    check_val("uf_done_cyc", 64'(done_cyc), 64'd16);
    check_val("uf_pops", 64'(npop), 64'd2);
    check_val("uf_sticky", 64'(underflow), 64'd1);

    // Starts while busy (SHIFT and DONE) are ignored; new Start clears underflow.
    push(32'h11223344);
    push(32'h55667788);
    run_xfer(6'd8, 0, 32'h0, (32'h1 << 5) | (32'h1 << 11));
    check_val("busy_uf_cleared", 64'(uf_at1), 64'd0);
    check_val("busy_bytes", bytes_seen, 64'h1122334455667788);
    check_val("busy_nvalid", 64'(nvalid), 64'd8);
    check_val("busy_done_cnt", 64'(done_cnt), 64'd1);
    check_val("busy_pops", 64'(npop), 64'd2);
    check_val("busy_idle_end", 64'(busy), 64'd0);

    // Reset while in SHIFT at lane 1.
    push(32'h11223344);
    push(32'h55667788);
    @(negedge CLK);
    Start  = 1'b1;
    len_in = 6'd8;
    found  = 1'b0;
    for (int c = 1; c <= 10 && !found; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (valid && cnt == 2'd1) found = 1'b1;
    end
    check_val("rst_reached_lane1", 64'(found), 64'd1);
    RESETn = 1'b0;
    #1;
    check_val("rst_outputs_now", 64'({busy, valid, done, rd_en, underflow, cnt, ser}), 64'h0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    pop_before = pop_cnt;
    repeat (6) @(negedge CLK);
    check_val("rst_no_rd_en", 64'(pop_cnt - pop_before), 64'd0);
    check_val("rst_idle", 64'({busy, valid, done}), 64'h0);

    check_val("rd_en_never_empty", 64'(bad_rd), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
